// File: rtl/tanimoto_job_ctrl.sv
// tanimoto_job_ctrl: run-level sequencer (threshold load, data run, pair drain).
// Optional DRAIN watchdog with o_Timeout: define TANIMOTO_JOB_WATCHDOG_EN.
module tanimoto_job_ctrl #(
  parameter int VECTOR_WIDTH   = 920,
  parameter int CNT_WIDTH      = $clog2(VECTOR_WIDTH),
  parameter int TBL_DEPTH      = VECTOR_WIDTH + 1,
  parameter int PAIR_CNT_WIDTH = 32
`ifdef TANIMOTO_JOB_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      i_Start,
  input  logic [CNT_WIDTH-1:0]      S_AXIS_CFG_tdata,
  input  logic                      S_AXIS_CFG_tvalid,
  output logic                      S_AXIS_CFG_tready,
  output logic [CNT_WIDTH-1:0]      o_BRAM_Addr,
  output logic [CNT_WIDTH-1:0]      o_BRAM_Din,
  output logic                      o_BRAM_En,
  output logic                      o_BRAM_WrEn,
  input  logic                      i_Data_Valid,
  input  logic                      i_Data_Last,
  output logic                      o_Data_Ready,
  output logic                      o_Pipe_Valid,
  input  logic                      i_Pipe_Read,
  input  logic                      i_Pair_Valid,
  input  logic                      i_Pair_Ready,
  input  logic                      i_Pair_Last,
  output logic                      o_Busy,
  output logic                      o_Done,
  output logic [PAIR_CNT_WIDTH-1:0] o_PairCount,
  output logic [2:0]                o_State
`ifdef TANIMOTO_JOB_WATCHDOG_EN
  ,
  output logic                      o_Timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  logic [1:0]                rst_sync_q;
  logic                      rst_s;
  state_t                    state_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic [CNT_WIDTH-1:0]      cnt_d;
  logic [CNT_WIDTH-1:0]      addr_q;
  logic [CNT_WIDTH-1:0]      din_q;
  logic                      en_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      last_q;
  logic [PAIR_CNT_WIDTH-1:0] pair_cnt_q;
  logic [PAIR_CNT_WIDTH-1:0] pair_cnt_d;

  logic in_load;
  logic in_run;
  logic cfg_hs;
  logic data_hs;
  logic pair_hs;
  logic pair_last_now;
  logic tbl_final;

  // Reset asserts at once, releases two ap_clk edges later.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) rst_sync_q <= 2'b11;
    else        rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_s = rst_sync_q[1];

  assign in_load       = (state_q == S_LOAD);
  assign in_run        = (state_q == S_RUN);
  assign cfg_hs        = in_load & S_AXIS_CFG_tvalid;
  assign data_hs       = in_run & i_Data_Valid & i_Pipe_Read & i_Data_Last;
  assign pair_hs       = (in_run | (state_q == S_DRAIN))
                         & i_Pair_Valid & i_Pair_Ready;
  assign pair_last_now = pair_hs & i_Pair_Last;
  assign tbl_final     = (cnt_q == CNT_WIDTH'(TBL_DEPTH - 1));
  assign cnt_d         = cnt_q + CNT_WIDTH'(1);
  assign pair_cnt_d    = (pair_cnt_q == '1) ? pair_cnt_q
                         : pair_cnt_q + PAIR_CNT_WIDTH'(1);

`ifdef TANIMOTO_JOB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
  logic            timeout_q;
  logic            wd_hit;

  assign wd_d      = pair_hs ? '0 : wd_q + WD_W'(1);
  assign wd_hit    = (wd_d == WD_W'(TIMEOUT_CYCLES));
  assign o_Timeout = timeout_q;
`endif

  // Job FSM with registered BRAM port, status and pair counter.
  always_ff @(posedge ap_clk or posedge rst_s) begin
    if (rst_s) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
      pair_cnt_q <= '0;
`ifdef TANIMOTO_JOB_WATCHDOG_EN
      wd_q       <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      if (pair_hs) pair_cnt_q <= pair_cnt_d;
      if (pair_last_now) last_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (i_Start) begin
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            pair_cnt_q <= '0;
`ifdef TANIMOTO_JOB_WATCHDOG_EN
            timeout_q  <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (cfg_hs) begin
            addr_q <= cnt_q;
            din_q  <= S_AXIS_CFG_tdata;
            en_q   <= 1'b1;
            cnt_q  <= cnt_d;
            if (tbl_final) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (data_hs) begin
            state_q <= S_DRAIN;
`ifdef TANIMOTO_JOB_WATCHDOG_EN
            wd_q    <= '0;
`endif
          end
        end
        S_DRAIN: begin
          if (last_q | pair_last_now) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
`ifdef TANIMOTO_JOB_WATCHDOG_EN
          else if (wd_hit) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
          wd_q <= wd_d;
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXIS_CFG_tready = in_load;
  assign o_Pipe_Valid      = in_run & i_Data_Valid;
  assign o_Data_Ready      = in_run & i_Pipe_Read;
  assign o_BRAM_Addr       = addr_q;
  assign o_BRAM_Din        = din_q;
  assign o_BRAM_En         = en_q;
  assign o_BRAM_WrEn       = en_q;
  assign o_Busy            = busy_q;
  assign o_Done            = done_q;
  assign o_PairCount       = pair_cnt_q;
  assign o_State           = state_q;

endmodule

// File: tb/tb_tanimoto_job_ctrl.sv
// Bench for tanimoto_job_ctrl: random cfg/pair traffic vs. a job-level model.
// Watchdog checks are built when TANIMOTO_JOB_WATCHDOG_EN is defined.
module tb_tanimoto_job_ctrl;
  localparam int CW  = 10;
  localparam int PW  = 32;
  localparam int TBL = 4;

  logic          clk = 1'b0;
  logic          ap_rst;
  logic          i_Start;
  logic [CW-1:0] cfg_tdata;
  logic          cfg_tvalid;
  logic          cfg_tready;
  logic [CW-1:0] bram_addr;
  logic [CW-1:0] bram_din;
  logic          bram_en;
  logic          bram_we;
  logic          i_Data_Valid;
  logic          i_Data_Last;
  logic          o_Data_Ready;
  logic          o_Pipe_Valid;
  logic          i_Pipe_Read;
  logic          i_Pair_Valid;
  logic          i_Pair_Ready;
  logic          i_Pair_Last;
  logic          o_Busy;
  logic          o_Done;
  logic [PW-1:0] o_PairCount;
  logic [2:0]    o_State;
`ifdef TANIMOTO_JOB_WATCHDOG_EN
  logic          o_Timeout;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  tanimoto_job_ctrl #(
    .TBL_DEPTH(TBL)
`ifdef TANIMOTO_JOB_WATCHDOG_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .ap_clk            (clk),
    .ap_rst            (ap_rst),
    .i_Start           (i_Start),
    .S_AXIS_CFG_tdata  (cfg_tdata),
    .S_AXIS_CFG_tvalid (cfg_tvalid),
    .S_AXIS_CFG_tready (cfg_tready),
    .o_BRAM_Addr       (bram_addr),
    .o_BRAM_Din        (bram_din),
    .o_BRAM_En         (bram_en),
    .o_BRAM_WrEn       (bram_we),
    .i_Data_Valid      (i_Data_Valid),
    .i_Data_Last       (i_Data_Last),
    .o_Data_Ready      (o_Data_Ready),
    .o_Pipe_Valid      (o_Pipe_Valid),
    .i_Pipe_Read       (i_Pipe_Read),
    .i_Pair_Valid      (i_Pair_Valid),
    .i_Pair_Ready      (i_Pair_Ready),
    .i_Pair_Last       (i_Pair_Last),
    .o_Busy            (o_Busy),
    .o_Done            (o_Done),
    .o_PairCount       (o_PairCount),
    .o_State           (o_State)
`ifdef TANIMOTO_JOB_WATCHDOG_EN
    , .o_Timeout       (o_Timeout)
`endif
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_pair(input logic v, input logic r, input logic l);
    i_Pair_Valid = v;
    i_Pair_Ready = r;
    i_Pair_Last  = l;
  endtask

  // Start from IDLE; a pair handshake in IDLE must not be counted.
  task automatic start_job();
    set_pair(1'b1, 1'b1, 1'b1);
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    set_pair(1'b0, 1'b0, 1'b0);
    exp_cnt = 0;
    chk("start_state", o_State, 1);
    chk("start_busy", o_Busy, 1);
    chk("start_cnt", o_PairCount, 0);
  endtask

  // Table load with random gaps; writes appear one cycle after accept.
  task automatic do_load();
    int k = 0;
    int cyc = 0;
    logic v;
    logic [CW-1:0] d;
    while (k < TBL) begin
      v = (cyc > 40) ? 1'b1 : (($urandom % 3) != 0);
      d = CW'($urandom);
      cfg_tvalid   = v;
      cfg_tdata    = d;
      i_Data_Valid = 1'b1;
      #1;
      chk("load_tready", cfg_tready, 1);
      chk("load_pvalid", o_Pipe_Valid, 0);
      tick();
      cyc++;
      chk("wr_en", bram_en, v);
      chk("wr_we", bram_we, v);
      if (v) begin
        chk("wr_addr", bram_addr, k);
        chk("wr_din", bram_din, d);
        k++;
      end
      chk("load_state", o_State, (k < TBL) ? 1 : 2);
    end
    cfg_tvalid   = 1'b0;
    i_Data_Valid = 1'b0;
  endtask

  // Three data beats, pipe read 1,0,1,1, last on the third beat.
  task automatic do_run(input bit early);
    logic [3:0] rd = 4'b1101;
    logic hs;
    for (int i = 0; i < 4; i++) begin
      i_Start      = (i == 0);
      i_Data_Valid = 1'b1;
      i_Pipe_Read  = rd[i];
      i_Data_Last  = (i == 3);
      cfg_tvalid   = 1'b1;
      if (early && i == 1) set_pair(1'b1, 1'b1, 1'b1);
      else set_pair(1'($urandom), 1'($urandom), 1'b0);
      hs = i_Pair_Valid & i_Pair_Ready;
      #1;
      chk("run_dready", o_Data_Ready, rd[i]);
      chk("run_pvalid", o_Pipe_Valid, 1);
      chk("run_tready", cfg_tready, 0);
      if (hs) exp_cnt++;
      tick();
      chk("run_state", o_State, (i < 3) ? 2 : 3);
      chk("run_cnt", o_PairCount, exp_cnt);
      if (i == 0) chk("run_no_wr", bram_en, 0);
    end
    i_Start      = 1'b0;
    i_Data_Valid = 1'b0;
    i_Pipe_Read  = 1'b0;
    i_Data_Last  = 1'b0;
    cfg_tvalid   = 1'b0;
    set_pair(1'b0, 1'b0, 1'b0);
  endtask

  // Drain until pair last, then DONE pulse and IDLE.
  task automatic do_drain(input bit early);
    int n = 0;
    int idle = 0;
    int cyc = 0;
    logic v;
    logic r;
    i_Data_Valid = 1'b1;
    i_Pipe_Read  = 1'b1;
    #1;
    chk("drain_pvalid", o_Pipe_Valid, 0);
    chk("drain_dready", o_Data_Ready, 0);
    i_Data_Valid = 1'b0;
    i_Pipe_Read  = 1'b0;
    if (early) begin
      set_pair(1'b1, 1'b1, 1'b0);
      exp_cnt++;
      tick();
    end else begin
      while (n < 6 && cyc < 60) begin
        if (cyc < 2) begin
          v = 1'b1;
          r = 1'b0;
        end else if (idle >= 4) begin
          v = 1'b1;
          r = 1'b1;
        end else begin
          v = (($urandom % 4) != 0);
          r = (($urandom % 4) != 0);
        end
        i_Pair_Valid = v;
        i_Pair_Ready = r;
        i_Pair_Last  = (v & r) ? (n == 5) : 1'($urandom);
        if (v & r) begin
          n++;
          exp_cnt++;
          idle = 0;
        end else begin
          idle++;
        end
        cyc++;
        tick();
        chk("drain_state", o_State, (n == 6) ? 4 : 3);
        chk("drain_cnt", o_PairCount, exp_cnt);
      end
    end
    chk("done_pulse", o_Done, 1);
    chk("done_busy", o_Busy, 0);
    chk("done_state", o_State, 4);
    chk("done_cnt", o_PairCount, exp_cnt);
    i_Start = 1'b1;
    set_pair(1'b1, 1'b1, 1'b1);
    tick();
    i_Start = 1'b0;
    set_pair(1'b0, 1'b0, 1'b0);
    chk("post_state", o_State, 0);
    chk("post_done", o_Done, 0);
    chk("post_cnt", o_PairCount, exp_cnt);
    tick();
    chk("idle_state", o_State, 0);
    chk("idle_cnt", o_PairCount, exp_cnt);
  endtask

  initial begin
    ap_rst       = 1'b1;
    i_Start      = 1'b0;
    cfg_tdata    = '0;
    cfg_tvalid   = 1'b0;
    i_Data_Valid = 1'b0;
    i_Data_Last  = 1'b0;
    i_Pipe_Read  = 1'b0;
    set_pair(1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    ap_rst = 1'b0;
    repeat (3) tick();

    i_Data_Valid = 1'b1;
    i_Pipe_Read  = 1'b1;
    cfg_tvalid   = 1'b1;
    #1;
    chk("rst_state", o_State, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_done", o_Done, 0);
    chk("rst_cnt", o_PairCount, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_tready", cfg_tready, 0);
    chk("rst_pvalid", o_Pipe_Valid, 0);
    chk("rst_dready", o_Data_Ready, 0);
    i_Data_Valid = 1'b0;
    i_Pipe_Read  = 1'b0;
    cfg_tvalid   = 1'b0;

    start_job();
    do_load();
    do_run(1'b0);
    do_drain(1'b0);

    start_job();
    do_load();
    do_run(1'b1);
    do_drain(1'b1);

    start_job();
    cfg_tvalid = 1'b1;
    cfg_tdata  = CW'($urandom);
    tick();
    cfg_tdata  = CW'($urandom);
    tick();
    chk("pre_rst_addr", bram_addr, 1);
    chk("pre_rst_en", bram_en, 1);
    ap_rst = 1'b1;
    #1;
    chk("arst_state", o_State, 0);
    chk("arst_busy", o_Busy, 0);
    chk("arst_en", bram_en, 0);
    chk("arst_we", bram_we, 0);
    chk("arst_addr", bram_addr, 0);
    chk("arst_din", bram_din, 0);
    chk("arst_tready", cfg_tready, 0);
    chk("arst_cnt", o_PairCount, 0);
    cfg_tvalid = 1'b0;
    tick();
    ap_rst = 1'b0;
    repeat (3) tick();
    chk("arst_idle", o_State, 0);

    start_job();
    do_load();
    do_run(1'b0);
`ifdef TANIMOTO_JOB_WATCHDOG_EN
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("wd_state", o_State, (j < 8) ? 3 : 4);
    end
    chk("wd_timeout", o_Timeout, 1);
    chk("wd_done", o_Done, 1);
    tick();
    chk("wd_idle", o_State, 0);
    chk("wd_hold", o_Timeout, 1);
    start_job();
    chk("wd_clear", o_Timeout, 0);
`else
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("stuck_state", o_State, 3);
      chk("stuck_busy", o_Busy, 1);
    end
    set_pair(1'b1, 1'b1, 1'b1);
    exp_cnt++;
    tick();
    set_pair(1'b0, 1'b0, 1'b0);
    chk("stuck_done", o_Done, 1);
    chk("stuck_cnt", o_PairCount, exp_cnt);
    tick();
    chk("stuck_idle", o_State, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tanimoto_job_ctrl.md
Name: tanimoto_job_ctrl

Overview:
Run-level sequencer for the tanimoto accelerator pipeline. On a start request it loads the comparator threshold table into the comparator BRAM over port A from a config stream. It then opens the vector data stream into the pipeline and monitors the ID-pair output stream until the final pair. It reports completion, pair count and state to the host-side control logic.

Parameters:
VECTOR_WIDTH, 920, fingerprint width in bits
CNT_WIDTH, $clog2(VECTOR_WIDTH), BRAM address/data width (popcount width)
TBL_DEPTH, 921, threshold entries written per run (popcounts 0..VECTOR_WIDTH)
PAIR_CNT_WIDTH, 32, width of the emitted-pair counter
TIMEOUT_CYCLES, 65535, watchdog limit in DRAIN (used only with the optional feature)

Ports:
ap_clk  in  1  clock for all logic
ap_rst  in  1  asynchronous, active-high reset
i_Start  in  1  start request; sampled only in IDLE
S_AXIS_CFG_tdata  in  CNT_WIDTH  threshold entry
S_AXIS_CFG_tvalid  in  1  cfg beat valid
S_AXIS_CFG_tready  out  1  cfg beat accepted
o_BRAM_Addr  out  CNT_WIDTH  comparator BRAM address
o_BRAM_Din  out  CNT_WIDTH  comparator BRAM write data
o_BRAM_En  out  1  BRAM enable
o_BRAM_WrEn  out  1  BRAM write enable
i_Data_Valid  in  1  upstream S_AXIS_DATA_tvalid
i_Data_Last  in  1  upstream S_AXIS_DATA_tlast
o_Data_Ready  out  1  upstream S_AXIS_DATA_tready
o_Pipe_Valid  out  1  gated i_Valid to pipeline
i_Pipe_Read  in  1  pipeline o_Read
i_Pair_Valid  in  1  monitored M_AXIS_ID_PAIR_tvalid
i_Pair_Ready  in  1  monitored M_AXIS_ID_PAIR_tready
i_Pair_Last  in  1  monitored M_AXIS_ID_PAIR_tlast
o_Busy  out  1  high in LOAD, RUN, DRAIN
o_Done  out  1  one-cycle completion pulse
o_PairCount  out  PAIR_CNT_WIDTH  pair handshakes in the current/last run
o_State  out  3  encoded state

Behaviour:
- States and encoding: IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4.
- Reset: async assert drives the FSM to IDLE and clears every output and counter to 0, mid-operation included. Release is synchronised to ap_clk.
- IDLE -> LOAD on i_Start=1. On that edge o_PairCount, the address counter and the pair-last flag clear. i_Start in any other state is ignored.
- LOAD:
  - S_AXIS_CFG_tready = 1. Each beat with tvalid&tready registers o_BRAM_Addr = address counter, o_BRAM_Din = tdata and o_BRAM_En = o_BRAM_WrEn = 1 for exactly the next cycle. Write latency is 1 cycle.
  - With no beat, En/WrEn = 0 next cycle.
  - The address counter increments per accepted beat. Acceptance at count TBL_DEPTH-1 moves to RUN. That final write is presented in the first RUN cycle.
  - tready = 0 in all other states; cfg tlast is not used.
- RUN:
  - o_Pipe_Valid = i_Data_Valid, combinational.
  - o_Data_Ready = i_Pipe_Read, combinational.
  - Both are forced to 0 outside RUN.
  - A data beat with i_Data_Valid&i_Pipe_Read&i_Data_Last moves to DRAIN next cycle.
- Pair monitoring (RUN and DRAIN):
  - Each cycle with i_Pair_Valid&i_Pair_Ready increments o_PairCount, saturating at all-ones.
  - A handshake with i_Pair_Last sets a sticky pair-last flag.
  - Handshakes outside RUN/DRAIN are not counted.
- DRAIN -> DONE when the pair-last flag is set or is being set this cycle. If pair last arrived while in RUN, DRAIN lasts exactly 1 cycle.
- DONE: o_Done = 1 for this single cycle, then IDLE unconditionally. An i_Start during DONE is ignored.
- o_PairCount holds its value after DONE until the next accepted start.
- o_Busy = 1 exactly in states 1-3.

Optional Feature:
Macro: TANIMOTO_JOB_WATCHDOG_EN.
- Defined:
  - Adds output o_Timeout (1 bit, reset 0).
  - A cycle counter clears on entry to DRAIN and on every pair handshake, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to DONE with o_Timeout = 1. o_Timeout holds until the next accepted start.
  - A pair-last handshake in the same cycle as the counter reaching TIMEOUT_CYCLES wins, and o_Timeout stays 0.
- Undefined: no port, no counter; DRAIN waits indefinitely.

Test Plan:
- TBL_DEPTH=4, pulse i_Start, send cfg 5,7,9,11 back-to-back -> BRAM writes addr0..3 = 5,7,9,11 on consecutive cycles, 1 cycle after each accept; RUN entered after the 4th accept; tready low afterwards.
- In RUN, drive 3 data beats with i_Pipe_Read toggling 1,0,1,1 and last on beat 3 -> o_Data_Ready mirrors i_Pipe_Read; o_Pipe_Valid is 0 in LOAD/DRAIN; DRAIN entered the cycle after the last-beat handshake.
- In DRAIN, 6 pair handshakes including 2 cycles with valid=1/ready=0, last on the 6th -> o_PairCount=6; o_Done high exactly 1 cycle; IDLE next.
- Pair last handshake during RUN before data last -> DRAIN lasts 1 cycle, then DONE; count includes all RUN handshakes.
- Assert ap_rst mid-LOAD after 2 cfg beats -> immediate IDLE, all outputs 0; a new start reloads from addr 0.
- With the watchdog macro and TIMEOUT_CYCLES=8, no pairs in DRAIN -> DONE after 8 cycles, o_Timeout=1; without the macro, the FSM stays in DRAIN.
